run_ctrl: RTL and testbench

Program-run sequencer for the single-cycle RISC-V core in `top`. It streams a program image word by word into instruction memory while the core is held in reset, then releases the core. It watches the core PC for either of two halt addresses (`<fin>`) and reports completion, the halt PC and the cycle count, or a watchdog timeout. It replaces bench-side reset and halt polling so that regressions and on-board runs use one sequencing path.

---
 rtl/run_ctrl_if.sv | 22 ++
 rtl/run_ctrl.sv | 141 ++++++++++++++
 tb/tb_run_ctrl.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/run_ctrl_if.sv
// Program-image load stream between a word source and run_ctrl.
// master drives the words; slave (run_ctrl) returns ready.
interface run_ctrl_if;
   logic        valid;
   logic        ready;
   logic [31:0] data;
   logic        last;

   modport master (
      output valid,
      output data,
      output last,
      input  ready
   );

   modport slave (
      input  valid,
      input  data,
      input  last,
      output ready
   );
endinterface

// File: rtl/run_ctrl.sv
// Program-run sequencer: load imem, hold core in reset, run, detect halt.
// RUN_CTRL_WATCHDOG_EN enables the TIMEOUT watchdog and the TOUT state.
module run_ctrl #(
   parameter int          IMEM_WORDS = 64,
   parameter logic [31:0] HALT_PC0   = 32'h000000bc,
   parameter logic [31:0] HALT_PC1   = 32'h00000100,
   parameter int          TIMEOUT    = 50000,
   localparam int         AW         = $clog2(IMEM_WORDS)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   run_ctrl_if.slave     ld,
   output logic          imem_we,
   output logic [AW-1:0] imem_addr,
   output logic [31:0]   imem_wdata,
   output logic          core_reset,
   input  logic [31:0]   pc,
   output logic          busy,
   output logic          done,
   output logic          timeout,
   output logic [31:0]   halt_pc,
   output logic [31:0]   cycles
);

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      HOLD,
      RUN,
`ifdef RUN_CTRL_WATCHDOG_EN
      TOUT,
`endif
      DONE
   } state_t;

   state_t        state;
   state_t        next;
   logic [AW-1:0] addr;
   logic          hold_cnt;
   logic          take;
   logic          last_word;
   logic          halt_hit;
   logic          load_go;

   assign take      = ld.valid & ld.ready;
   assign last_word = ld.last | (addr == AW'(IMEM_WORDS - 1));
   assign halt_hit  = (pc == HALT_PC0) | (pc == HALT_PC1);
   assign load_go   = (state != LOAD) & (next == LOAD);

   assign imem_we    = take;
   assign imem_addr  = addr;
   assign imem_wdata = ld.ready ? ld.data : 32'd0;

`ifdef RUN_CTRL_WATCHDOG_EN
   logic wd_hit;
   assign wd_hit = (cycles == 32'(TIMEOUT - 1));
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= next;
   end

   always_comb begin
      next       = state;
      ld.ready   = 1'b0;
      core_reset = 1'b1;
      unique case (state)
         IDLE: if (start) next = LOAD;
         LOAD: begin
            ld.ready = 1'b1;
            if (take && last_word) next = HOLD;
         end
         HOLD: if (hold_cnt) next = RUN;
         RUN: begin
            core_reset = 1'b0;
            if (halt_hit) next = DONE;
`ifdef RUN_CTRL_WATCHDOG_EN
            else if (wd_hit) next = TOUT;
`endif
         end
`ifdef RUN_CTRL_WATCHDOG_EN
         TOUT: begin
            core_reset = 1'b0;
            if (start) next = LOAD;
         end
`endif
         DONE: begin
            core_reset = 1'b0;
            if (start) next = LOAD;
         end
         default: next = IDLE;
      endcase
   end

   // the last address ends the load, so addr is held there, never wrapped
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         addr     <= '0;
         hold_cnt <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         halt_pc  <= 32'd0;
         cycles   <= 32'd0;
      end else begin
         busy     <= (next == LOAD) | (next == HOLD)
                   | (next == RUN);
         hold_cnt <= (state == HOLD) & ~hold_cnt;
         if (load_go) begin
            addr   <= '0;
            done   <= 1'b0;
            cycles <= 32'd0;
         end else if (take && !(addr == AW'(IMEM_WORDS - 1))) begin
            addr <= addr + AW'(1);
         end
         if (state == RUN) begin
            if (halt_hit) begin
               halt_pc <= pc;
               done    <= 1'b1;
            end
`ifdef RUN_CTRL_WATCHDOG_EN
            else if (!wd_hit) cycles <= cycles + 32'd1;
`else
            else if (cycles != 32'hffffffff) cycles <= cycles + 32'd1;
`endif
         end
      end
   end

`ifdef RUN_CTRL_WATCHDOG_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)                             timeout <= 1'b0;
      else if (load_go)                       timeout <= 1'b0;
      else if (state == RUN && !halt_hit && wd_hit) timeout <= 1'b1;
   end
`else
   assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_run_ctrl.sv
// Scoreboard bench for run_ctrl: imem writes and run results are queued
// by the stimulus and popped by a monitor as the DUT produces them.
module tb_run_ctrl;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        imem_we;
   logic [5:0]  imem_addr;
   logic [31:0] imem_wdata;
   logic        core_reset;
   logic [31:0] pc;
   logic        busy;
   logic        done;
   logic        timeout;
   logic [31:0] halt_pc;
   logic [31:0] cycles;
   logic [31:0] pc_base = 32'd0;
   logic [31:0] pc_step = 32'd0;
   logic [31:0] mem [64];
   logic [37:0] wq [$];
   logic [65:0] rq [$];
   logic        fin_q = 1'b0;
   int          checks = 0;
   int          fails = 0;
   int          acc;

   run_ctrl_if ld ();

   always #5 clk = ~clk;

   run_ctrl #(
      .IMEM_WORDS (64),
      .HALT_PC0   (32'h000000bc),
      .HALT_PC1   (32'h00000100),
      .TIMEOUT    (100)
   ) dut (
      .clk        (clk),
      .reset      (rst_n),
      .start      (start),
      .ld         (ld),
      .imem_we    (imem_we),
      .imem_addr  (imem_addr),
      .imem_wdata (imem_wdata),
      .core_reset (core_reset),
      .pc         (pc),
      .busy       (busy),
      .done       (done),
      .timeout    (timeout),
      .halt_pc    (halt_pc),
      .cycles     (cycles)
   );

   // core stand-in: pc walks from pc_base by pc_step, spins at a halt PC
   always @(posedge clk) begin
      if (core_reset) pc <= pc_base;
      else if (pc != 32'hbc && pc != 32'h100) pc <= pc + pc_step;
   end

   always @(posedge clk) if (imem_we) mem[imem_addr] <= imem_wdata;

   task automatic chk(input string nm, input logic [65:0] act,
                      input logic [65:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (imem_we) begin
         if (wq.size() == 0) begin
            checks++;
            fails++;
            $display("FAIL stray_write: got addr %0d data %0h expected none",
                     imem_addr, imem_wdata);
         end else begin
            chk("imem_write", {imem_addr, imem_wdata}, wq.pop_front());
         end
      end
      if ((done | timeout) && !fin_q) begin
         if (rq.size() == 0) begin
            checks++;
            fails++;
            $display("FAIL stray_result: got done %b timeout %b expected none",
                     done, timeout);
         end else begin
            chk("result", {done, timeout, halt_pc, cycles}, rq.pop_front());
         end
      end
      fin_q = done | timeout;
   end

   function automatic logic [31:0] word(input int i);
      return (i * 32'h01010101) ^ 32'h00000013;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input int n, input int last, input bit hold_chk,
                       output int cnt);
      cnt = 0;
      step();
      start = 1'b1;
      step();
      start = 1'b0;
      for (int i = 0; i < n; i++) begin
         if (!ld.ready) break;
         ld.valid = 1'b1;
         ld.data  = word(i);
         ld.last  = (i == last);
         wq.push_back({6'(i), word(i)});
         cnt++;
         step();
      end
      ld.valid = 1'b0;
      ld.last  = 1'b0;
      if (hold_chk) begin
         chk("hold_edge1_core_reset", core_reset, 1);
         chk("hold_ld_ready", ld.ready, 0);
         step();
         chk("hold_edge2_core_reset", core_reset, 1);
         step();
         chk("run_edge3_core_reset", core_reset, 0);
         chk("run_busy", busy, 1);
      end
   endtask

   task automatic wait_fin(input int budget);
      int k = 0;
      while (!(done | timeout) && k < budget) begin
         step();
         k++;
      end
      if (!(done | timeout)) begin
         checks++;
         fails++;
         $display("FAIL wait_fin: got no halt expected one within %0d", budget);
      end
      step();
      chk("fin_busy", busy, 0);
   endtask

   initial begin
      #300000;
      $display("FAIL global_timeout: got hang expected finish");
      $fatal(1);
   end

   initial begin
      ld.valid = 1'b0;
      ld.data  = 32'd0;
      ld.last  = 1'b0;
      #1;
      chk("rst_ld_ready", ld.ready, 0);
      chk("rst_imem_we", imem_we, 0);
      chk("rst_imem_addr", imem_addr, 0);
      chk("rst_imem_wdata", imem_wdata, 0);
      chk("rst_core_reset", core_reset, 1);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_timeout", timeout, 0);
      chk("rst_halt_pc", halt_pc, 0);
      chk("rst_cycles", cycles, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // reset in the middle of a load
      load(3, -1, 1'b0, acc);
      chk("midload_addr", imem_addr, 3);
      chk("midload_core_reset", core_reset, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("async_core_reset", core_reset, 1);
      chk("async_ld_ready", ld.ready, 0);
      chk("async_imem_addr", imem_addr, 0);
      chk("async_busy", busy, 0);
      @(negedge clk);
      rst_n = 1'b1;

      // cipher program: 47 words, halt at 0xbc after 47 RUN cycles
      pc_base = 32'h0;
      pc_step = 32'd4;
      rq.push_back({1'b1, 1'b0, 32'h000000bc, 32'd47});
      load(47, 46, 1'b1, acc);
      chk("cipher_words", acc, 47);
      wait_fin(300);
      for (int i = 0; i < 47; i++) chk("cipher_imem", mem[i], word(i));

      // sort program with a start pulse during RUN
      pc_base = 32'hc0;
      pc_step = 32'd4;
      rq.push_back({1'b1, 1'b0, 32'h00000100, 32'd16});
      load(5, 4, 1'b1, acc);
      repeat (3) step();
      start    = 1'b1;
      ld.valid = 1'b1;
      ld.data  = 32'hdeadbeef;
      step();
      start    = 1'b0;
      ld.valid = 1'b0;
      chk("start_in_run_busy", busy, 1);
      chk("start_in_run_core_reset", core_reset, 0);
      wait_fin(300);

      // halt on the same cycle the watchdog limit is reached
      pc_base = 32'h28c;
      pc_step = 32'hfffffffc;
      rq.push_back({1'b1, 1'b0, 32'h00000100, 32'd99});
      load(4, 3, 1'b1, acc);
      wait_fin(300);

      // program looping outside both halt PCs
      pc_base = 32'h200;
      pc_step = 32'd0;
`ifdef RUN_CTRL_WATCHDOG_EN
      rq.push_back({1'b0, 1'b1, 32'h00000100, 32'd99});
      load(2, 1, 1'b1, acc);
      wait_fin(300);
`else
      load(2, 1, 1'b1, acc);
      repeat (300) step();
      chk("loop_busy", busy, 1);
      chk("loop_timeout", timeout, 0);
      chk("loop_done", done, 0);
      chk("loop_cycles_running", cycles > 32'd99, 1);
`endif
      #2 rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;

      // 70 words, no last marker: load stops at address 63
      load(70, -1, 1'b1, acc);
      chk("overflow_words", acc, 64);
      chk("overflow_addr_held", imem_addr, 63);
      chk("overflow_imem63", mem[63], word(63));
      repeat (3) step();
      chk("overflow_ld_ready", ld.ready, 0);

      step();
      chk("writes_drained", wq.size(), 0);
      chk("results_drained", rq.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end
endmodule
